choice_1of5_debounce: RTL and testbench

- Upstream input stage of the 1-of-5 selector path.
- Takes five raw, asynchronous, bouncing switch/key lines and synchronises each into the system clock domain.
- Debounces each line independently and presents a clean registered 5-bit vector to the downstream 1-of-5 choice decoder.
- Emits a one-cycle change strobe so the downstream logic re-evaluates its selection only when the vector changes.

---
 rtl/choice_pkg.sv | 12 +
 rtl/choice_db_chan.sv | 50 +++++
 rtl/choice_1of5_debounce.sv | 45 ++++
 tb/tb_choice_1of5_debounce.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/choice_pkg.sv
// Shared definitions for the 1-of-5 selector path (debounce, decoder, encoder).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package choice_pkg;

  localparam int CH_N              = 5;
  localparam int DEFAULT_DB_CYCLES = 8;

  // Channel index, wide enough for CH_N=5; shared with the decoder/encoder.
  typedef logic [2:0] ch_idx_t;

endpackage

// File: rtl/choice_db_chan.sv
// Single-channel two-flop synchroniser plus debounce counter and stable level.
// Latency: stable_o/upd_o change DB_CYCLES+1 edges after raw_i is first sampled (tick_i=1).
// Backpressure: none; raw_i is sampled every clock, counting advances only on tick_i.
module choice_db_chan #(
  parameter int DB_CYCLES = choice_pkg::DEFAULT_DB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic raw_i,
  output logic stable_o,
  output logic upd_o
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // s1 may go metastable; only s2 is ever used by the debounce logic.
  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Synchronise every clock; count consecutive ticks where s2 differs from the
  // stable level, any agreement restarts the count from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      cnt      <= '0;
      stable_o <= 1'b0;
      upd_o    <= 1'b0;
    end else begin
      s1    <= raw_i;
      s2    <= s1;
      upd_o <= 1'b0;
      if (s2 == stable_o) begin
        cnt <= '0;
      end else if (tick_i) begin
        if (cnt == CNT_LAST) begin
          stable_o <= s2;
          cnt      <= '0;
          upd_o    <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/choice_1of5_debounce.sv
// Debounces CH_N raw switch lines into a registered vector plus a change strobe.
// Latency: level sampled at edge k appears on x_o (with chg_o) after edge k+DB_CYCLES+2 at tick_i=1.
// Backpressure: none; outputs are levels/pulses, the downstream decoder must accept every change.
module choice_1of5_debounce
  import choice_pkg::*;
#(
  parameter int CH_N      = choice_pkg::CH_N,
  parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick_i,
  input  logic [CH_N-1:0] sw_i,
  output logic [CH_N-1:0] x_o,
  output logic            chg_o
);

  logic [CH_N-1:0] stable;
  logic [CH_N-1:0] upd;

  for (genvar g = 0; g < CH_N; g++) begin : g_chan
    choice_db_chan #(
      .DB_CYCLES (DB_CYCLES)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_i   (tick_i),
      .raw_i    (sw_i[g]),
      .stable_o (stable[g]),
      .upd_o    (upd[g])
    );
  end

  // Register the vector and strobe together so chg_o marks the first cycle of a new x_o.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_o   <= '0;
      chg_o <= 1'b0;
    end else begin
      x_o   <= stable;
      chg_o <= |upd;
    end
  end

endmodule

// File: tb/tb_choice_1of5_debounce.sv
// Self-checking bench for choice_1of5_debounce: directed sequences, a vector
// table, and a randomized phase compared against a cycle-level reference model.
module tb_choice_1of5_debounce;

  localparam int DB  = 8;
  localparam int CHN = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           tick_i;
  logic [CHN-1:0] sw_i;
  logic [CHN-1:0] x_o;
  logic           chg_o;

  always #5 clk = ~clk;

  choice_1of5_debounce #(
    .CH_N      (CHN),
    .DB_CYCLES (DB)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_i (tick_i),
    .sw_i   (sw_i),
    .x_o    (x_o),
    .chg_o  (chg_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit mdl_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel follows the synchronised level once it has
  // disagreed with the stable level for DB consecutive enabled ticks.
  logic [CHN-1:0] m_s1, m_s2, m_stab, m_x, m_upd;
  logic           m_chg;
  int             m_run [CHN];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_stab = '0; m_x = '0; m_upd = '0; m_chg = 1'b0;
      for (int c = 0; c < CHN; c++) m_run[c] = 0;
    end else begin
      m_x   = m_stab;
      m_chg = |m_upd;
      m_upd = '0;
      for (int c = 0; c < CHN; c++) begin
        if (m_s2[c] == m_stab[c]) begin
          m_run[c] = 0;
        end else if (tick_i) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == DB) begin
            m_stab[c] = m_s2[c];
            m_run[c]  = 0;
            m_upd[c]  = 1'b1;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = sw_i;
    end
  end

  always @(negedge clk) begin
    if (mdl_en) begin
      chk("model_x", 32'(x_o), 32'(m_x));
      chk("model_chg", 32'(chg_o), 32'(m_chg));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive a new level and check x_o stays at old for DB+2 edges, then updates
  // for exactly one chg_o cycle.
  task automatic press(input logic [CHN-1:0] old_v, input logic [CHN-1:0] new_v, input string name);
    int seen;
    seen = 0;
    sw_i = new_v;
    repeat (DB + 2) begin
      step();
      if (chg_o) seen++;
    end
    chk({name, "_early_x"}, 32'(x_o), 32'(old_v));
    chk({name, "_early_chg"}, 32'(seen), 32'd0);
    step();
    chk({name, "_x"}, 32'(x_o), 32'(new_v));
    chk({name, "_chg"}, 32'(chg_o), 32'd1);
    step();
    chk({name, "_chg_width"}, 32'(chg_o), 32'd0);
  endtask

  typedef struct {
    logic [CHN-1:0] sw;
    logic           tick;
    int             cyc;
    logic [CHN-1:0] x;
    logic           chg;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int seen;

    tbl[0] = '{5'b10000, 1'b1,  6, 5'b00000, 1'b0};  // short glitch
    tbl[1] = '{5'b00000, 1'b1, 12, 5'b00000, 1'b0};  // glitch never reaches x_o
    tbl[2] = '{5'b00001, 1'b1, 11, 5'b00001, 1'b1};
    tbl[3] = '{5'b00001, 1'b1,  1, 5'b00001, 1'b0};
    tbl[4] = '{5'b00011, 1'b1, 10, 5'b00001, 1'b0};
    tbl[5] = '{5'b00011, 1'b1,  1, 5'b00011, 1'b1};
    tbl[6] = '{5'b00011, 1'b0, 20, 5'b00011, 1'b0};
    tbl[7] = '{5'b00000, 1'b0, 20, 5'b00011, 1'b0};  // no ticks, no progress
    tbl[8] = '{5'b00000, 1'b1,  8, 5'b00011, 1'b0};
    tbl[9] = '{5'b00000, 1'b1,  1, 5'b00000, 1'b1};

    rst_n  = 1'b0;
    tick_i = 1'b1;
    sw_i   = 5'b11111;

    // Reset held with all switches pressed.
    for (int i = 0; i < 3; i++) begin
      step();
      mdl_en = 1'b1;
      chk("reset_x", 32'(x_o), 32'd0);
      chk("reset_chg", 32'(chg_o), 32'd0);
    end
    rst_n = 1'b1;
    step();
    chk("post_reset_x", 32'(x_o), 32'd0);
    chk("post_reset_chg", 32'(chg_o), 32'd0);
    repeat (DB + 1) step();
    chk("post_reset_early_x", 32'(x_o), 32'd0);
    step();
    chk("post_reset_x_all", 32'(x_o), 32'h1f);
    chk("post_reset_chg_all", 32'(chg_o), 32'd1);

    press(5'b11111, 5'b00000, "release_all");
    press(5'b00000, 5'b00100, "clean");
    press(5'b00100, 5'b00000, "clean_rel");
    press(5'b00000, 5'b10010, "simul");
    press(5'b10010, 5'b00000, "simul_rel");

    // Bounce on channel 0: 3-cycle runs for 24 cycles.
    seen = 0;
    for (int c = 0; c < 24; c++) begin
      sw_i[0] = ((c / 3) % 2 == 0);
      step();
      if (chg_o) seen++;
    end
    chk("bounce_chg", 32'(seen), 32'd0);
    chk("bounce_x", 32'(x_o), 32'd0);
    press(5'b00000, 5'b00001, "bounce_final");
    press(5'b00001, 5'b00000, "bounce_rel");

    // Tick every 4th edge; the first ticked edge is the first one that sees s2 changed.
    seen = 0;
    for (int i = 0; i < 32; i++) begin
      tick_i = (i % 4 == 2);
      if (i == 0) sw_i = 5'b01000;
      step();
      if (i < 31 && (x_o != 5'b00000 || chg_o)) seen++;
    end
    chk("tick_early", 32'(seen), 32'd0);
    chk("tick_x", 32'(x_o), 32'h08);
    chk("tick_chg", 32'(chg_o), 32'd1);
    tick_i = 1'b1;
    step();
    press(5'b01000, 5'b00000, "tick_rel");

    // Reset after 5 counted ticks discards the partial count.
    sw_i = 5'b00010;
    repeat (7) step();
    chk("midrst_pre_x", 32'(x_o), 32'd0);
    rst_n = 1'b0;
    step();
    chk("midrst_x", 32'(x_o), 32'd0);
    rst_n = 1'b1;
    seen = 0;
    repeat (DB + 2) begin
      step();
      if (x_o != 5'b00000) seen++;
    end
    chk("midrst_early", 32'(seen), 32'd0);
    step();
    chk("midrst_after_x", 32'(x_o), 32'h02);
    chk("midrst_after_chg", 32'(chg_o), 32'd1);
    press(5'b00010, 5'b00000, "midrst_rel");

    // Vector table.
    for (int v = 0; v < 10; v++) begin
      sw_i   = tbl[v].sw;
      tick_i = tbl[v].tick;
      repeat (tbl[v].cyc) step();
      chk($sformatf("tbl%0d_x", v), 32'(x_o), 32'(tbl[v].x));
      chk($sformatf("tbl%0d_chg", v), 32'(chg_o), 32'(tbl[v].chg));
    end

    // Randomized phase: slow random switch activity, random tick, rare resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) sw_i = sw_i ^ 5'($urandom_range(1, 31));
      tick_i = ($urandom_range(0, 3) != 0);
      rst_n  = ($urandom_range(0, 999) != 0);
      step();
    end
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
